fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Owns the single write port of the 12-bit x 64K dual-port frame RAM and shares it between the
//  renderer (port 0) and the host/CPU (port 1), with a built-in bulk clear sequencer.
//  Sits between the pixel producers and the frame RAM; the read port stays with the video scan-out.
// PARAMETERS
//  D_WIDTH     12  pixel word width, must match RAM d_width
//  ADDR_WIDTH  16  RAM address width; clear covers 0 .. (1<<ADDR_WIDTH)-1
// PORTS
//  clk               in   1           single clock, all logic posedge
//  reset             in   1           synchronous, active-high
//  r_valid           in   1           renderer write request
//  r_ready           out  1           renderer request accepted this cycle
//  r_address         in   ADDR_WIDTH  renderer write address
//  r_data            in   D_WIDTH     renderer write data
//  h_valid           in   1           host write request
//  h_ready           out  1           host request accepted this cycle
//  h_address         in   ADDR_WIDTH  host write address
//  h_data            in   D_WIDTH     host write data
//  clear_start       in   1           pulse: start filling the whole RAM with clear_color
//  clear_color       in   D_WIDTH     fill value, sampled when clear_start is accepted
//  clear_busy        out  1           clear in progress
//  clear_done        out  1           one-cycle pulse after the last clear write issues
//  ram_write_enable  out  1           to RAM write_enable
//  ram_write_address out  ADDR_WIDTH  to RAM write_address
//  ram_data_inn      out  D_WIDTH     to RAM data_inn
// BEHAVIOUR
//  - Reset: state ARB, all outputs 0, last_grant = host (so the renderer wins the first tie).
//  - Handshake: transfer when valid && ready. ready is combinational from state/last_grant/valids.
//    Requester holds address/data stable until ready. ready is never high without valid.
//  - ARB state: only one valid -> grant it. Both valid -> grant the port not granted last time
//    (round-robin). last_grant updates only on a transfer.
//  - Latency: ram_* outputs are registered. A transfer in cycle N drives ram_write_enable=1 with
//    that address/data in cycle N+1. ram_write_enable=0 in cycles with no transfer/clear write.
//  - clear_start in ARB: that cycle's port grant still completes. Latch clear_color, counter=0,
//    and go to CLEAR next cycle. clear_start while in CLEAR is ignored.
//  - CLEAR state: r_ready=h_ready=0. One write per cycle, address = counter, data = latched
//    colour, counter +1. Counter is ADDR_WIDTH wide. Leave when the write to all-ones issues.
//    Address wrap-around is therefore never written twice. clear_busy=1 for exactly
//    1<<ADDR_WIDTH cycles.
//  - clear_done: high for 1 cycle, in the cycle the RAM sees the final (all-ones) write.
//    The state returns to ARB in that same cycle, so arbitration resumes immediately.
//  - Reset during CLEAR: aborts. No clear_done, busy=0, ram_write_enable=0 the next cycle.
//    RAM contents are left partially cleared.
// CONFIGURATION
//  FB_ARB_STATS_EN defined:
//   - adds outputs r_grant_count and h_grant_count, each 32 bits, saturating.
//   - adds output clear_count, 16 bits, wrapping.
//   - r_grant_count and h_grant_count increment per transfer.
//   - clear_count increments per clear_done.
//   - All three are zeroed by reset.
//  FB_ARB_STATS_EN undefined: these ports and counters do not exist; the rest is identical.
// STRUCTURE
//  - Package fb_pkg:
//    - localparams FB_D_WIDTH=12 and FB_ADDR_WIDTH=16.
//    - typedef enum logic [0:0] {ARB, CLEAR} fb_arb_state_t.
//    - typedef fb_port_t {REND, HOST} for last_grant.
//  - Sub-module fb_clear_seq: address counter, colour latch, done detection. Interface start/busy/done/addr.
//  - The top block holds the FSM, the round-robin, the output registers and the optional stats.
// TESTING
//  - Reset, then r_valid only, addr 0x0010, data 0xABC.
//    -> r_ready=1 in the same cycle; the next cycle has we=1, addr 0x0010, data 0xABC.
//  - Both valid for 4 cycles with distinct addr/data.
//    -> grants R,H,R,H; RAM sees the matching writes in that order, 1 cycle later.
//  - ADDR_WIDTH=4, clear_start with colour 0x555.
//    -> busy high for 16 cycles; writes to 0x0..0xF all 0x555; done pulses with the 0xF write.
//  - h_valid held during a clear.
//    -> h_ready=0 throughout; granted in the cycle done pulses; write issues 1 cycle later.
//  - clear_start and r_valid in the same ARB cycle.
//    -> the renderer write lands first, then clear writes 0x0.. follow; the renderer data is overwritten.
//  - Reset asserted mid-clear at addr 0x7.
//    -> no done pulse, busy=0 and we=0 the next cycle; a second clear_start restarts at 0x0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the frame-buffer write arbiter.
package fb_pkg;

  localparam int FB_D_WIDTH    = 12;
  localparam int FB_ADDR_WIDTH = 16;

  typedef enum logic [0:0] {ARB, CLEAR} fb_arb_state_t;
  typedef enum logic [0:0] {REND, HOST} fb_port_t;

endpackage

// File: rtl/fb_clear_seq.sv
// Bulk-clear sequencer: walks every RAM address once with a latched fill colour.
module fb_clear_seq
  import fb_pkg::*;
#(
  parameter int D_WIDTH    = FB_D_WIDTH,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  busy_i,
  input  logic [D_WIDTH-1:0]    color_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [D_WIDTH-1:0]    color_o,
  output logic                  last_o,
  output logic                  done_o
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [D_WIDTH-1:0]    color_q;
  logic                  done_q;

  // Final write is the one issued while the counter sits at all-ones.
  assign last_o  = busy_i && (addr_q == '1);
  assign addr_o  = addr_q;
  assign color_o = color_q;
  assign done_o  = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= last_o;
      if (start_i) begin
        addr_q <= '0;
      end else if (busy_i) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      color_q <= color_i;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin owner of the frame RAM write port (renderer vs host) with a bulk clear.
// Optional grant/clear statistics are built when FB_ARB_STATS_EN is defined.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int D_WIDTH    = FB_D_WIDTH,
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [ADDR_WIDTH-1:0] r_address,
  input  logic [D_WIDTH-1:0]    r_data,
  input  logic                  h_valid,
  output logic                  h_ready,
  input  logic [ADDR_WIDTH-1:0] h_address,
  input  logic [D_WIDTH-1:0]    h_data,
  input  logic                  clear_start,
  input  logic [D_WIDTH-1:0]    clear_color,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_write_address,
  output logic [D_WIDTH-1:0]    ram_data_inn
`ifdef FB_ARB_STATS_EN
  ,
  output logic [31:0]           r_grant_count,
  output logic [31:0]           h_grant_count,
  output logic [15:0]           clear_count
`endif
);

  fb_arb_state_t         state_q, state_d;
  fb_port_t              last_grant_q, last_grant_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [D_WIDTH-1:0]    ram_data_q, ram_data_d;

  logic                  r_xfer, h_xfer, clr_accept, clr_issue, clr_last, clr_done;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [D_WIDTH-1:0]    clr_color;

  assign clr_accept = (state_q == ARB) && clear_start;
  assign clr_issue  = (state_q == CLEAR);

  fb_clear_seq #(
    .D_WIDTH    (D_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .start_i (clr_accept),
    .busy_i  (clr_issue),
    .color_i (clear_color),
    .addr_o  (clr_addr),
    .color_o (clr_color),
    .last_o  (clr_last),
    .done_o  (clr_done)
  );

  // A lone requester always wins; on a tie the port not granted last goes first.
  always_comb begin
    r_ready = 1'b0;
    h_ready = 1'b0;
    if (state_q == ARB) begin
      r_ready = r_valid && (!h_valid || (last_grant_q == HOST));
      h_ready = h_valid && (!r_valid || (last_grant_q == REND));
    end
  end

  assign r_xfer = r_valid && r_ready;
  assign h_xfer = h_valid && h_ready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_data_d   = ram_data_q;
    case (state_q)
      ARB:     if (clr_accept) state_d = CLEAR;
      CLEAR:   if (clr_last)   state_d = ARB;
      default: state_d = ARB;
    endcase
    if (r_xfer) begin
      last_grant_d = REND;
      ram_we_d     = 1'b1;
      ram_addr_d   = r_address;
      ram_data_d   = r_data;
    end else if (h_xfer) begin
      last_grant_d = HOST;
      ram_we_d     = 1'b1;
      ram_addr_d   = h_address;
      ram_data_d   = h_data;
    end else if (clr_issue) begin
      ram_we_d     = 1'b1;
      ram_addr_d   = clr_addr;
      ram_data_d   = clr_color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      last_grant_q <= HOST;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_data_q   <= ram_data_d;
    end
  end

  assign clear_busy        = clr_issue;
  assign clear_done        = clr_done;
  assign ram_write_enable  = ram_we_q;
  assign ram_write_address = ram_addr_q;
  assign ram_data_inn      = ram_data_q;

`ifdef FB_ARB_STATS_EN
  logic [31:0] r_grant_q, h_grant_q;
  logic [15:0] clear_cnt_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_q   <= '0;
      h_grant_q   <= '0;
      clear_cnt_q <= '0;
    end else begin
      if (r_xfer)   r_grant_q   <= sat_inc32(r_grant_q);
      if (h_xfer)   h_grant_q   <= sat_inc32(h_grant_q);
      if (clr_done) clear_cnt_q <= clear_cnt_q + 16'd1;
    end
  end

  assign r_grant_count = r_grant_q;
  assign h_grant_count = h_grant_q;
  assign clear_count   = clear_cnt_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench: full-width instance for arbitration, 4-bit-address instance for clear.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        r_valid, h_valid;
  logic [15:0] r_address, h_address;
  logic [11:0] r_data, h_data, clear_color;
  logic        cs16, cs4;

  logic        r_ready16, h_ready16, busy16, done16, we16;
  logic [15:0] waddr16;
  logic [11:0] wdata16;
  logic        r_ready4, h_ready4, busy4, done4, we4;
  logic [3:0]  waddr4;
  logic [11:0] wdata4;
`ifdef FB_ARB_STATS_EN
  logic [31:0] rgc16, hgc16, rgc4, hgc4;
  logic [15:0] cc16, cc4;
`endif

  int vectors = 0;
  int miscompares = 0;

  fb_write_arbiter dut (
    .clk(clk), .reset(reset),
    .r_valid(r_valid), .r_ready(r_ready16), .r_address(r_address), .r_data(r_data),
    .h_valid(h_valid), .h_ready(h_ready16), .h_address(h_address), .h_data(h_data),
    .clear_start(cs16), .clear_color(clear_color),
    .clear_busy(busy16), .clear_done(done16),
    .ram_write_enable(we16), .ram_write_address(waddr16), .ram_data_inn(wdata16)
`ifdef FB_ARB_STATS_EN
    , .r_grant_count(rgc16), .h_grant_count(hgc16), .clear_count(cc16)
`endif
  );

  fb_write_arbiter #(.D_WIDTH(12), .ADDR_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .r_valid(r_valid), .r_ready(r_ready4), .r_address(r_address[3:0]), .r_data(r_data),
    .h_valid(h_valid), .h_ready(h_ready4), .h_address(h_address[3:0]), .h_data(h_data),
    .clear_start(cs4), .clear_color(clear_color),
    .clear_busy(busy4), .clear_done(done4),
    .ram_write_enable(we4), .ram_write_address(waddr4), .ram_data_inn(wdata4)
`ifdef FB_ARB_STATS_EN
    , .r_grant_count(rgc4), .h_grant_count(hgc4), .clear_count(cc4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; r_valid = 1'b0; h_valid = 1'b0;
    r_address = '0; h_address = '0; r_data = '0; h_data = '0;
    cs16 = 1'b0; cs4 = 1'b0; clear_color = '0;
    tick(); tick();

    // Reset state
    chk("rst_we", we16, 0);
    chk("rst_addr", waddr16, 0);
    chk("rst_data", wdata16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_r_ready", r_ready16, 0);
    chk("rst_h_ready", h_ready16, 0);
    chk("rst_we4", we4, 0);
    chk("rst_busy4", busy4, 0);
    reset = 1'b0;

    // Single renderer write
    r_valid = 1'b1; r_address = 16'h0010; r_data = 12'hABC;
    #1;
    chk("t1_r_ready", r_ready16, 1);
    chk("t1_h_ready", h_ready16, 0);
    tick();
    r_valid = 1'b0;
    chk("t1_we", we16, 1);
    chk("t1_addr", waddr16, 32'h0010);
    chk("t1_data", wdata16, 32'hABC);
    tick();
    chk("t1_we_idle", we16, 0);

    // Both requesting for four cycles: R,H,R,H after a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r_valid = 1'b1; h_valid = 1'b1;
      r_address = 16'(32'h0100 + k); r_data = 12'(32'h100 + k);
      h_address = 16'(32'h0200 + k); h_data = 12'(32'h200 + k);
      #1;
      chk("t2_r_ready", r_ready16, (k % 2 == 0) ? 1 : 0);
      chk("t2_h_ready", h_ready16, (k % 2 == 1) ? 1 : 0);
      tick();
      chk("t2_we", we16, 1);
      chk("t2_addr", waddr16, (k % 2 == 0) ? 32'h0100 + k : 32'h0200 + k);
      chk("t2_data", wdata16, (k % 2 == 0) ? 32'h100 + k : 32'h200 + k);
    end
    r_valid = 1'b0; h_valid = 1'b0;
    tick();
    chk("t2_we_idle", we16, 0);

    // 16-entry clear with colour 0x555, host held waiting throughout
    reset = 1'b1; tick(); reset = 1'b0;
    cs4 = 1'b1; clear_color = 12'h555;
    chk("t3_busy_before", busy4, 0);
    tick();
    cs4 = 1'b0; clear_color = 12'h000;
    h_valid = 1'b1; h_address = 16'h0009; h_data = 12'h777;
    for (int i = 0; i < 16; i++) begin
      chk("t3_busy", busy4, 1);
      chk("t4_h_ready", h_ready4, 0);
      chk("t3_done_low", done4, 0);
      if (i > 0) begin
        chk("t3_we", we4, 1);
        chk("t3_addr", waddr4, 32'(i - 1));
        chk("t3_data", wdata4, 32'h555);
      end
      tick();
    end
    chk("t3_busy_end", busy4, 0);
    chk("t3_done", done4, 1);
    chk("t3_we_last", we4, 1);
    chk("t3_addr_last", waddr4, 32'hF);
    chk("t3_data_last", wdata4, 32'h555);
    chk("t4_h_ready_at_done", h_ready4, 1);
    tick();
    h_valid = 1'b0;
    chk("t4_done_pulse", done4, 0);
    chk("t4_we", we4, 1);
    chk("t4_addr", waddr4, 32'h9);
    chk("t4_data", wdata4, 32'h777);
    tick();
    chk("t4_we_idle", we4, 0);

    // Clear start together with a renderer write; then reset at address 7
    r_valid = 1'b1; r_address = 16'h0003; r_data = 12'h123;
    cs4 = 1'b1; clear_color = 12'h0AA;
    #1;
    chk("t5_r_ready", r_ready4, 1);
    tick();
    r_valid = 1'b0; cs4 = 1'b0;
    chk("t5_we", we4, 1);
    chk("t5_addr", waddr4, 32'h3);
    chk("t5_data", wdata4, 32'h123);
    chk("t5_busy", busy4, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t5_clr_we", we4, 1);
      chk("t5_clr_addr", waddr4, 32'(i));
      chk("t5_clr_data", wdata4, 32'h0AA);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_busy_abort", busy4, 0);
    chk("t6_we_abort", we4, 0);
    chk("t6_done_abort", done4, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_done", done4, 0);
      chk("t6_no_we", we4, 0);
    end
    cs4 = 1'b1; clear_color = 12'h3C3;
    tick();
    cs4 = 1'b0;
    tick();
    chk("t6_restart_we", we4, 1);
    chk("t6_restart_addr", waddr4, 32'h0);
    chk("t6_restart_data", wdata4, 32'h3C3);
    n = 0;
    while (done4 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t6_done_seen", done4, 1);
    chk("t6_final_addr", waddr4, 32'hF);
    chk("t6_final_data", wdata4, 32'h3C3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
